inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameters SHALL be:
  - RESET_PC, default 32'h0000_0000, first fetch address after reset.
  - BUF_DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-002 Port clk SHALL be an input, width 1: the single rising-edge clock.
REQ-003 Port rst_n SHALL be an input, width 1: asynchronous, active-low reset.
REQ-004 Port imem_req SHALL be an output, width 1: fetch request valid.
REQ-005 Port imem_addr SHALL be an output, width 32: fetch address, word-aligned.
REQ-006 Port imem_gnt SHALL be an input, width 1: memory accepts the request this cycle.
REQ-007 Port imem_rvalid SHALL be an input, width 1: read data valid; responses return in order.
REQ-008 Port imem_rdata SHALL be an input, width 32: instruction word.
REQ-009 Port redirect SHALL be an input, width 1: taken branch/jump from the execute stage.
REQ-010 Port redirect_pc SHALL be an input, width 32: new fetch target.
REQ-011 Port inst SHALL be an output, width 32: instruction to the decode/control path.
REQ-012 Port inst_pc SHALL be an output, width 32: PC of inst.
REQ-013 Port inst_valid SHALL be an output, width 1: inst and inst_pc are valid.
REQ-014 Port inst_ready SHALL be an input, width 1: decode consumes the instruction this cycle.
REQ-015 Port fetch_misalign SHALL be an output, width 1: misaligned redirect flag (see Configuration).

Function
REQ-016 Request issue:
  - imem_req SHALL be high only when the FSM is in RUN, redirect is low, and occupancy + outstanding < BUF_DEPTH.
  - imem_addr SHALL equal the fetch PC.
REQ-017 Request handshake:
  - A request is accepted on imem_req & imem_gnt.
  - On acceptance, the fetch PC SHALL advance by 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
  - On acceptance, outstanding SHALL increment.
  - imem_addr SHALL stay stable while imem_req is high and imem_gnt is low.
REQ-018 Response handling in RUN:
  - imem_rvalid SHALL push {imem_rdata, request PC} into the buffer.
  - imem_rvalid SHALL decrement outstanding.
  - Accept-to-rvalid latency is 1 or more cycles.
  - inst_valid SHALL rise the cycle after rvalid (registered, no bypass).
REQ-019 Buffer output:
  - The buffer is FIFO.
  - inst_valid = buffer non-empty.
  - A pop occurs on inst_valid & inst_ready.
  - Push and pop in the same cycle SHALL leave occupancy unchanged.
  - Overflow is impossible by REQ-016.
  - inst_ready while empty SHALL be ignored.
REQ-020 The FSM SHALL have two states:
  - RUN: normal fetch.
  - DRAIN: discarding stale responses; no requests are issued.
REQ-021 Redirect (any state):
  - The fetch PC SHALL load redirect_pc.
  - The buffer SHALL flush; inst_valid is low the next cycle.
  - discard SHALL load discard + outstanding + (imem_req & imem_gnt).
  - outstanding SHALL clear.
  - A pop in the same cycle SHALL be ignored.
  - Next state SHALL be DRAIN if the new discard is nonzero, else RUN.
REQ-022 DRAIN:
  - Each imem_rvalid SHALL decrement discard, and the data SHALL be dropped.
  - The FSM SHALL go to RUN when discard reaches 0.
  - Requests SHALL resume the cycle after entering RUN.
REQ-023 A redirect coinciding with imem_rvalid SHALL count that response as discarded; it is not pushed.

Reset
REQ-024 While rst_n is low, the following SHALL take effect asynchronously:
  - fetch PC = RESET_PC.
  - FSM = RUN.
  - Buffer empty.
  - outstanding = 0 and discard = 0.
  - imem_req = 0, inst_valid = 0.
  - inst = 0, inst_pc = 0.
  - fetch_misalign = 0.
REQ-025 The first request SHALL assert on the first rising edge after rst_n deasserts.
REQ-026 Reset mid-transaction SHALL drop all in-flight state.
  - Responses arriving after reset are not supported; the memory is reset together with this block.

Configuration
REQ-027 Macro INST_FETCH_MISALIGN_CHECK_EN.
  - Defined:
    - A redirect with redirect_pc[1:0] != 0 SHALL set fetch_misalign the next cycle.
    - fetch_misalign SHALL hold imem_req low until a redirect with aligned redirect_pc arrives, which clears it.
  - Undefined:
    - redirect_pc[1:0] SHALL be forced to 2'b00.
    - fetch_misalign SHALL be constant 0.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
  - Reset release, gnt=1, rvalid 1 cycle after accept, ready=1: imem_addr = 0,4,8,...; first inst_valid at cycle 3 with inst_pc=0.
  - ready=0 with BUF_DEPTH=2: exactly 2 requests accepted; imem_req then low; raising ready pops in order, PC 0 then 4.
  - Redirect to 32'h100 with 2 outstanding: FSM DRAIN; two rvalids dropped; next imem_addr = 32'h100; no stale inst_valid.
  - Redirect same cycle as rvalid and pop: buffer empty next cycle; discard excludes that response.
  - PC 32'hFFFF_FFFC accepted: next imem_addr = 32'h0.
  - Macro defined, redirect_pc = 32'h102: fetch_misalign=1 and imem_req=0; aligned redirect to 32'h200 clears the flag and fetching resumes at 32'h200.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues word fetches, buffers in-order responses, flushes on redirect.
// Optional misaligned-redirect trap is enabled by defining INST_FETCH_MISALIGN_CHECK_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_misalign
);
    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {RUN, DRAIN} state_t;
    state_t state, state_next;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] discard_load;
    logic [CW-1:0] count;
    logic [CW:0]   in_use;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   buf_data [BUF_DEPTH];
    logic [31:0]   buf_pc   [BUF_DEPTH];
    logic          accept;
    logic          push;
    logic          pop;
    logic          misalign;
    logic [31:0]   rsp_pc;
    logic [31:0]   target_pc;

`ifdef INST_FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else if (redirect) begin
            misalign <= |redirect_pc[1:0];
        end
    end
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc[1:0];
    assign misalign       = 1'b0;
`endif

    assign fetch_misalign = misalign;
    assign target_pc      = {redirect_pc[31:2], 2'b00};

    assign in_use    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req  = rst_n && (state == RUN) && !redirect && !misalign &&
                       (in_use < (CW+1)'(BUF_DEPTH));
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_gnt;

    assign push = (state == RUN) && imem_rvalid && !redirect;
    assign pop  = inst_valid && inst_ready && !redirect;

    // In RUN all in-flight requests are consecutive words ending just below fetch_pc,
    // so the oldest one (the response arriving now) sits outstanding words back.
    assign rsp_pc = fetch_pc - 32'({outstanding, 2'b00});

    assign discard_load = discard + outstanding + CW'(accept) - CW'(imem_rvalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = (discard_load != '0) ? DRAIN : RUN;
        end else if ((state == DRAIN) && imem_rvalid && (discard == CW'(1))) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect) begin
            fetch_pc    <= target_pc;
            outstanding <= '0;
            discard     <= discard_load;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(accept) - CW'(push);
            if ((state == DRAIN) && imem_rvalid) begin
                discard <= discard - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= imem_rdata;
                buf_pc[wr_ptr]   <= rsp_pc;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign inst       = buf_data[rd_ptr];
    assign inst_pc    = buf_pc[rd_ptr];
    assign inst_valid = (count != '0);

endmodule
